// File: rtl/monitor_event_arbiter.sv
// Round-robin arbiter that forwards on/off device events to an active-device monitor.
// Optional drop counter is enabled by defining MON_ARB_DROP_CNT_EN.
module monitor_event_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_valid,
  input  logic [3:0] req_dir,
  output logic [3:0] req_ready,
  input  logic       clear,
  output logic       mon_rst,
  output logic       change,
  output logic       on_off,
  output logic [7:0] shadow_count
`ifdef MON_ARB_DROP_CNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  typedef enum logic [1:0] {INIT, RUN, CLEAR} state_t;

  state_t     state;
  logic       init_cnt;
  logic [1:0] rr_ptr;
  logic [1:0] cand;
  logic [1:0] grant_idx;
  logic       grant_any;
  logic       grant_dir;
  logic       drop;

  // Grant is combinational; reset is folded in so nothing can be accepted while rst is high.
  always_comb begin
    req_ready = 4'b0000;
    grant_idx = rr_ptr;
    grant_any = 1'b0;
    cand      = rr_ptr;
    if (!rst && state == RUN && !clear) begin
      for (int k = 0; k < 4; k++) begin
        cand = rr_ptr + 2'(k);
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign grant_dir = req_dir[grant_idx];
  assign drop      = grant_dir ? (shadow_count == 8'hFF) : (shadow_count == 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      init_cnt     <= 1'b0;
      rr_ptr       <= 2'd0;
      shadow_count <= 8'h00;
      change       <= 1'b0;
      on_off       <= 1'b0;
      mon_rst      <= 1'b1;
    end else begin
      change <= 1'b0;
      case (state)
        INIT: begin
          if (init_cnt) begin
            state   <= RUN;
            mon_rst <= 1'b0;
          end else begin
            init_cnt <= 1'b1;
            mon_rst  <= 1'b1;
          end
        end
        RUN: begin
          if (clear) begin
            state        <= CLEAR;
            mon_rst      <= 1'b1;
            shadow_count <= 8'h00;
          end else if (grant_any) begin
            rr_ptr <= grant_idx + 2'd1;
            // Saturating events are consumed silently so the monitor never wraps.
            if (!drop) begin
              change       <= 1'b1;
              on_off       <= grant_dir;
              shadow_count <= grant_dir ? shadow_count + 8'd1 : shadow_count - 8'd1;
            end
          end
        end
        CLEAR: begin
          state   <= RUN;
          mon_rst <= 1'b0;
        end
        default: begin
          state   <= INIT;
          mon_rst <= 1'b1;
        end
      endcase
    end
  end

`ifdef MON_ARB_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= 8'h00;
    end else if (state == RUN && clear) begin
      drop_count <= 8'h00;
    end else if (grant_any && drop && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule
